// File: rtl/i2c_target_regbank_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------+
// | i2c_target_regbank_pkg: FSM state encoding and default address |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package i2c_target_regbank_pkg;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h42;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_target_regbank_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------+
// | i2c_target_regbank_line_filter: 2-FF sync, stability filter,   |
// | rise/fall pulses aligned with the filtered level change.        |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module i2c_target_regbank_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= i_din;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------+
// | i2c_target_regbank: I2C target giving the host access to an     |
// | 8-bit register space via write strobes and read requests.       |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module i2c_target_regbank
  import i2c_target_regbank_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         FILTER_LEN  = 4,
  parameter int         SDA_HOLD    = 8
) (
  input  logic       ICE_CLK,
  input  logic       rst,
  input  logic       scl_di,
  input  logic       sda_di,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int HOLD_W = $clog2(SDA_HOLD + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;
  logic [7:0] shift_in;

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              oe_tgt_q, oe_tgt_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_stb_q, wr_stb_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_req_q, rd_req_d;
  logic [7:0]        rd_addr_q, rd_addr_d;
  logic              ld_pend_q, ld_pend_d;
  logic              busy_q, busy_d;

  i2c_target_regbank_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(ICE_CLK), .rst(rst), .i_din(scl_di),
    .o_level(scl_lvl), .o_rise(scl_rise), .o_fall(scl_fall)
  );

  i2c_target_regbank_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(ICE_CLK), .rst(rst), .i_din(sda_di),
    .o_level(sda_lvl), .o_rise(sda_rise), .o_fall(sda_fall)
  );

  // An SDA edge coinciding with an SCL edge is a data transition, never START/STOP.
  assign start_det = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
  assign shift_in  = {shreg_q[6:0], sda_lvl};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    hold_cnt_d = hold_cnt_q;
    oe_tgt_d   = oe_tgt_q;
    sda_oe_d   = sda_oe_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    ld_pend_d  = rd_req_q;
    busy_d     = busy_q;

    // The drive level chosen at an SCL fall reaches the pad only after the hold time.
    if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
      if (hold_cnt_q == HOLD_W'(1)) sda_oe_d = oe_tgt_q;
    end
    if (ld_pend_q) shreg_d = rd_data;

    if (start_det || stop_det) begin
      state_d    = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d  = 4'd0;
      hold_cnt_d = '0;
      oe_tgt_d   = 1'b0;
      sda_oe_d   = 1'b0;
      if (stop_det) busy_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          shreg_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (state_q == ST_PTR) ptr_d = shift_in;
            if (state_q == ST_WDATA) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = shift_in;
              ptr_d     = ptr_q + 8'd1;
            end
          end
        end
        ST_RDATA: bit_cnt_d = bit_cnt_q + 4'd1;
        ST_ADDR_ACK: begin
          if (rw_q) begin
            rd_req_d  = 1'b1;
            rd_addr_d = ptr_q;
          end
        end
        ST_RDATA_ACK: begin
          if (!sda_lvl) begin
            ptr_d     = ptr_q + 8'd1;
            rd_req_d  = 1'b1;
            rd_addr_d = ptr_q + 8'd1;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      hold_cnt_d = HOLD_W'(SDA_HOLD);
      case (state_q)
        ST_ADDR: begin
          if (bit_cnt_q == 4'd8) begin
            if (shreg_q[7:1] == TARGET_ADDR) begin
              state_d  = ST_ADDR_ACK;
              rw_d     = shreg_q[0];
              busy_d   = 1'b1;
              oe_tgt_d = 1'b1;
            end else begin
              state_d  = ST_IGNORE;
              oe_tgt_d = 1'b0;
            end
          end
        end
        ST_PTR: begin
          if (bit_cnt_q == 4'd8) begin
            state_d  = ST_PTR_ACK;
            oe_tgt_d = 1'b1;
          end
        end
        ST_WDATA: begin
          if (bit_cnt_q == 4'd8) begin
            state_d  = ST_WDATA_ACK;
            oe_tgt_d = 1'b1;
          end
        end
        ST_ADDR_ACK: begin
          bit_cnt_d = 4'd0;
          if (rw_q) begin
            state_d  = ST_RDATA;
            oe_tgt_d = ~shreg_q[7];
          end else begin
            state_d  = ST_PTR;
            oe_tgt_d = 1'b0;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          state_d   = ST_WDATA;
          bit_cnt_d = 4'd0;
          oe_tgt_d  = 1'b0;
        end
        ST_RDATA: begin
          if (bit_cnt_q == 4'd8) begin
            state_d  = ST_RDATA_ACK;
            oe_tgt_d = 1'b0;
          end else begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            oe_tgt_d = ~shreg_q[6];
          end
        end
        // Only an ACKed byte stays here until the fall; a NACK already left for IGNORE.
        ST_RDATA_ACK: begin
          state_d   = ST_RDATA;
          bit_cnt_d = 4'd0;
          oe_tgt_d  = ~shreg_q[7];
        end
        default: oe_tgt_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ICE_CLK or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 8'd0;
      ptr_q      <= 8'd0;
      rw_q       <= 1'b0;
      hold_cnt_q <= '0;
      oe_tgt_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 8'd0;
      ld_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      hold_cnt_q <= hold_cnt_d;
      oe_tgt_q   <= oe_tgt_d;
      sda_oe_q   <= sda_oe_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      ld_pend_q  <= ld_pend_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------+
// | tb_i2c_target_regbank: I2C master bus model, register fabric    |
// | and transaction-level reference model.  Rev 1.0                 |
// +----------------------------------------------------------------+
module tb_i2c_target_regbank;

  localparam logic [6:0] ADDR7 = 7'h42;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic       sda_oe, wr_stb, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  wire        sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regbank dut (
    .ICE_CLK(clk), .rst(rst), .scl_di(scl_m), .sda_di(sda_line), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  // Fabric register file; unrequested cycles present garbage on rd_data.
  logic [7:0]  salt;
  logic [7:0]  fab_mem [256];
  bit          fab_init_done = 1'b0;
  int          oe_cnt = 0;
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return 8'(a * 8'd29) ^ salt;
  endfunction

  always @(posedge clk) begin
    if (!fab_init_done) begin
      for (int i = 0; i < 256; i++) fab_mem[i] <= init_val(8'(i));
      fab_init_done <= 1'b1;
    end
    if (wr_stb) begin
      fab_mem[wr_addr] <= wr_data;
      wr_log.push_back({wr_addr, wr_data});
    end
    if (rd_req) begin
      rd_data <= fab_mem[rd_addr];
      rd_log.push_back(rd_addr);
    end else begin
      rd_data <= 8'($urandom);
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  // Reference model: memory contents and the register pointer.
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr;
  logic [7:0] tx_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(20);
    scl_m = 1'b1; tick(20);
    sda_m = 1'b0; tick(20);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(20); sda_m = 1'b0;
    tick(20); scl_m = 1'b1;
    tick(20); sda_m = 1'b1;
    tick(20);
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    tick(20); sda_m = v;
    tick(20); scl_m = 1'b1;
    tick(8);
    if (glitch) begin
      scl_m = 1'b0; tick(2); scl_m = 1'b1;
    end else begin
      tick(2);
    end
    tick(10); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic r);
    tick(20); sda_m = 1'b1;
    tick(20); scl_m = 1'b1;
    tick(10); r = sda_line;
    tick(10); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_at, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_at);
    recv_bit(r);
    ack = ~r;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(r);
      b[i] = r;
    end
    send_bit(~ack, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] ptr, input int glitch_at);
    logic a;
    logic [7:0] p;
    logic [15:0] exp_q [$];
    wr_log.delete();
    bus_start();
    write_byte({ADDR7, 1'b0}, -1, a); check("w_addr_ack", a, 1);
    check("w_busy", busy, 1);
    write_byte(ptr, -1, a); check("w_ptr_ack", a, 1);
    p = ptr;
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], (i == 0) ? glitch_at : -1, a); check("w_data_ack", a, 1);
      exp_q.push_back({p, tx_q[i]});
      ref_mem[p] = tx_q[i];
      p = p + 8'd1;
    end
    ref_ptr = p;
    bus_stop();
    check("w_busy_after_p", busy, 0);
    check("w_stb_count", wr_log.size(), exp_q.size());
    foreach (exp_q[i]) if (i < wr_log.size()) check("w_stb_addr_data", wr_log[i], exp_q[i]);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] b, base;
    rd_log.delete();
    bus_start();
    if (set_ptr) begin
      write_byte({ADDR7, 1'b0}, -1, a); check("r_waddr_ack", a, 1);
      write_byte(ptr, -1, a); check("r_ptr_ack", a, 1);
      ref_ptr = ptr;
      bus_start();
    end
    write_byte({ADDR7, 1'b1}, -1, a); check("r_addr_ack", a, 1);
    base = ref_ptr;
    for (int i = 0; i < n; i++) begin
      read_byte(b, i < n - 1);
      check("r_data", b, ref_mem[8'(base + i)]);
    end
    ref_ptr = 8'(base + n - 1);
    tick(20); check("r_nack_release", sda_oe, 0);
    bus_stop();
    check("r_busy_after_p", busy, 0);
    check("r_req_count", rd_log.size(), n);
    for (int i = 0; i < n; i++) if (i < rd_log.size()) check("r_req_addr", rd_log[i], 8'(base + i));
  endtask

  initial begin
    logic a;
    int   oe_before, kind, n;
    salt = 8'($urandom);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    ref_ptr = 8'h00;

    tick(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    rst = 1'b0;
    tick(10);

    tx_q = '{8'hA5, 8'h5A};
    do_write(8'h10, -1);

    oe_before = oe_cnt;
    wr_log.delete(); rd_log.delete();
    bus_start();
    write_byte(8'h90, -1, a); check("bad_addr_nack", a, 0);
    check("bad_addr_busy", busy, 0);
    write_byte(8'h11, -1, a); check("bad_addr_byte_nack", a, 0);
    bus_stop();
    check("bad_addr_oe_never", oe_cnt - oe_before, 0);
    check("bad_addr_no_stb", wr_log.size(), 0);
    check("bad_addr_no_req", rd_log.size(), 0);
    check("bad_addr_busy_end", busy, 0);

    tx_q = '{8'h3C, 8'hC3};
    do_write(8'h20, -1);
    do_read(1'b1, 8'h20, 2);

    tx_q = '{8'($urandom), 8'($urandom)};
    do_write(8'hFF, -1);
    do_read(1'b1, 8'hFF, 2);

    tx_q = '{8'hA5};
    do_write(8'h50, 3);

    wr_log.delete();
    bus_start();
    write_byte({ADDR7, 1'b0}, -1, a); check("part_addr_ack", a, 1);
    write_byte(8'h60, -1, a); check("part_ptr_ack", a, 1);
    ref_ptr = 8'h60;
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    bus_stop();
    check("part_no_stb", wr_log.size(), 0);
    do_read(1'b0, 8'h00, 1);

    tx_q = '{8'h12};
    do_write(8'h30, -1);
    bus_start();
    write_byte({ADDR7, 1'b0}, -1, a); check("rst_t_addr_ack", a, 1);
    write_byte(8'h30, -1, a); check("rst_t_ptr_ack", a, 1);
    bus_start();
    write_byte({ADDR7, 1'b1}, -1, a); check("rst_t_raddr_ack", a, 1);
    tick(25);
    check("rst_t_driving_zero", sda_oe, 1);
    #2 rst = 1'b1;
    #1 check("rst_t_async_release", sda_oe, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    rst = 1'b0;
    ref_ptr = 8'h00;
    tick(20);
    do_read(1'b0, 8'h00, 1);
    tx_q = '{8'($urandom)};
    do_write(8'($urandom), -1);

    for (int k = 0; k < 6; k++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      if (kind == 0) begin
        tx_q.delete();
        for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
        do_write(8'($urandom), -1);
      end else if (kind == 1) begin
        do_read(1'b1, 8'($urandom), n);
      end else begin
        do_read(1'b0, 8'h00, n);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
